// File: rtl/sram_resp_pkg.sv
// Shared types and limits for the asynchronous SRAM responder.
// Holds the FSM state encoding and the wait-state bound.
// Includes a helper that turns a wait-state count into a counter preload.
package sram_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_WAIT,
    WR_WAIT,
    HOLD,
    RELEASE
  } SramSt;

  localparam int SRAM_WS_MAX = 15;

  // The wait counter is 4 bits and counts down to 0, so N wait states load N-1.
  // Out-of-range counts are clamped to 1..SRAM_WS_MAX.
  function automatic logic [3:0] ws_load(input int ws);
    int w;
    w = ws;
    if (w < 1) w = 1;
    if (w > SRAM_WS_MAX) w = SRAM_WS_MAX;
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/sram_resp.sv
// Turns each CPU byte-window strobe into exactly one timed cycle on a 16-bit async SRAM.
// Latency: dato 1+WS_RD edges after acceptance, done 2+WS_RD / 2+WS_WR edges after acceptance.
// Backpressure: busy is high from acceptance until the CPU strobe drops after completion.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int WS_RD  = 3,
  parameter int WS_WR  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic              req_oe,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_dati,
  output logic [7:0]        dato,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  logic       req;
  SramSt      state;
  logic [3:0] cnt;
  logic       wr_q;   // latched direction: 1 = write
  logic       a0_q;   // latched byte select: 1 = high lane

  assign req = req_ce & (req_oe | req_we);

  // FSM, wait counter, request latches and pin outputs in one registered process
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      a0_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dato       <= 8'h00;
      sram_addr  <= '0;
      sram_dq_o  <= 16'h0000;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      done <= 1'b0;

      // Pins are registered from the state held during the cycle just ending,
      // so each state's strobe pattern appears on the pins one edge later.
      case (state)
        SETUP: begin
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= wr_q;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= wr_q;
          // reads enable both lanes; writes enable only the addressed lane
          sram_lb_n  <= wr_q & a0_q;
          sram_ub_n  <= wr_q & ~a0_q;
        end
        RD_WAIT: begin
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        WR_WAIT: begin
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b0;
          sram_dq_oe <= 1'b1;
        end
        HOLD: begin
          // strobes rise while address, lanes, ce_n and data drive stay put
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          done      <= 1'b1;
        end
        default: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase

      case (state)
        IDLE: begin
          if (req) begin
            wr_q      <= req_we;
            a0_q      <= req_addr[0];
            sram_addr <= req_addr[ADDR_W-1:1];
            sram_dq_o <= {req_dati, req_dati};
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= wr_q ? ws_load(WS_WR) : ws_load(WS_RD);
          state <= wr_q ? WR_WAIT : RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            dato  <= a0_q ? sram_dq_i[15:8] : sram_dq_i[7:0];
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt == 4'd0) state <= HOLD;
          else             cnt   <= cnt - 4'd1;
        end
        HOLD: begin
          state <= RELEASE;
        end
        RELEASE: begin
          // a strobe still held from this access must drop before another is taken
          if (!req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_resp.sv
// Self-checking bench for sram_resp with a behavioural SRAM and a byte-level reference memory.
// Timing is observed on the falling edge; sample k sees the state after rising edge k-1 (edge 0 accepts).
// Randomized read/write mix is checked against the reference memory.
module tb_sram_resp;

  localparam int AW    = 22;
  localparam int WS_RD = 3;
  localparam int WS_WR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_ce, req_oe, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_dati;
  logic [7:0]    dato;
  logic          busy, done;
  logic [AW-2:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  int n_pass  = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  sram_resp #(.ADDR_W(AW), .WS_RD(WS_RD), .WS_WR(WS_WR)) dut (
    .clk(clk), .rst(rst),
    .req_ce(req_ce), .req_oe(req_oe), .req_we(req_we),
    .req_addr(req_addr), .req_dati(req_dati),
    .dato(dato), .busy(busy), .done(done),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  // Behavioural async SRAM: 256 words, upper address bits alias.
  logic [15:0] sram_mem [0:255];
  assign sram_dq_i = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? sram_mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (rst === 1'b0 && sram_ce_n === 1'b0 && sram_we_n === 1'b0) begin
      if (sram_lb_n === 1'b0) sram_mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
      if (sram_ub_n === 1'b0) sram_mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
    end
  end

  // Reference byte memory for the random test region (bytes 0..127) and expected dato.
  logic [7:0] ref_mem [0:127];
  logic [7:0] exp_dato;

  // Per-transaction observations.
  int          r_oe_low, r_we_low, r_oe_pulses, r_we_pulses, r_done, r_done_at;
  int          r_dato_at, r_busy_drop, r_we_rise, r_dqoe_fall;
  logic        r_busy1, r_lb_w, r_ub_w, r_lb_r, r_ub_r;
  logic [AW-2:0] r_waddr;
  logic [15:0]   r_dq;

  // Expected edge counts measured from acceptance, shifted by one for the falling-edge sample.
  function automatic int exp_busy_drop(input int ws, input int hold);
    int a;
    a = 4 + ws;
    return (hold + 1 > a) ? hold + 1 : a;
  endfunction

  task automatic drop_req();
    req_ce = 1'b0; req_oe = 1'b0; req_we = 1'b0;
  endtask

  // Issue one CPU strobe, hold it for 'hold' samples, and record pin activity for ncyc samples.
  task automatic run_req(input logic wr, input logic rd, input logic [AW-1:0] a,
                         input logic [7:0] d, input logic [7:0] xd, input int hold, input int ncyc);
    logic prev_we_n, prev_oe_n, prev_dq_oe;
    r_oe_low = 0; r_we_low = 0; r_oe_pulses = 0; r_we_pulses = 0; r_done = 0; r_done_at = -1;
    r_dato_at = -1; r_busy_drop = -1; r_we_rise = -1; r_dqoe_fall = -1; r_busy1 = 1'b0;
    r_lb_w = 1'bx; r_ub_w = 1'bx; r_lb_r = 1'bx; r_ub_r = 1'bx; r_waddr = 'x; r_dq = 'x;
    @(negedge clk);
    req_ce = 1'b1; req_oe = rd; req_we = wr; req_addr = a; req_dati = d;
    prev_we_n = 1'b1; prev_oe_n = 1'b1; prev_dq_oe = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (sram_oe_n === 1'b0) begin
        r_oe_low++;
        if (prev_oe_n) begin r_oe_pulses++; r_lb_r = sram_lb_n; r_ub_r = sram_ub_n; end
      end
      if (sram_we_n === 1'b0) begin
        r_we_low++;
        if (prev_we_n) begin
          r_we_pulses++; r_waddr = sram_addr; r_lb_w = sram_lb_n; r_ub_w = sram_ub_n; r_dq = sram_dq_o;
        end
      end
      if (sram_we_n === 1'b1 && !prev_we_n && r_we_rise < 0) r_we_rise = k;
      if (sram_dq_oe === 1'b0 && prev_dq_oe && r_dqoe_fall < 0) r_dqoe_fall = k;
      if (done === 1'b1) begin r_done++; if (r_done_at < 0) r_done_at = k; end
      if (r_dato_at < 0 && dato === xd) r_dato_at = k;
      if (k == 1) r_busy1 = busy;
      if (r_busy_drop < 0 && k > 1 && busy === 1'b0) r_busy_drop = k;
      prev_we_n = (sram_we_n !== 1'b0); prev_oe_n = (sram_oe_n !== 1'b0); prev_dq_oe = (sram_dq_oe === 1'b1);
      if (k == hold) drop_req();
    end
    drop_req();
  endtask

  task automatic test_reset();
    rst = 1'b1; drop_req(); req_addr = '0; req_dati = 8'h00;
    repeat (2) @(negedge clk);
    n_total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy, done} !== 8'b11111000)
      $display("FAIL reset_pins got=%b want=11111000",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy, done});
    else n_pass++;
    n_total++;
    if (dato !== 8'h00 || sram_addr !== '0) $display("FAIL reset_regs dato=%h addr=%h want 00/0", dato, sram_addr);
    else n_pass++;
    rst = 1'b0;
    exp_dato = 8'h00;
  endtask

  task automatic test_write();
    run_req(1'b1, 1'b0, 22'h000101, 8'h5A, exp_dato, 20, 24);
    n_total++;
    if (r_waddr !== 21'h80 || r_ub_w !== 1'b0 || r_lb_w !== 1'b1 || r_dq !== 16'h5A5A)
      $display("FAIL wr_pins addr=%h ub=%b lb=%b dq=%h want 80/0/1/5a5a", r_waddr, r_ub_w, r_lb_w, r_dq);
    else n_pass++;
    n_total++;
    if (r_we_low != WS_WR || r_we_pulses != 1) $display("FAIL wr_we_low got=%0d pulses=%0d want %0d/1", r_we_low, r_we_pulses, WS_WR);
    else n_pass++;
    n_total++;
    if (r_we_rise != WS_WR + 3 || r_dqoe_fall != r_we_rise + 1)
      $display("FAIL wr_dq_hold we_rise=%0d dqoe_fall=%0d want %0d/%0d", r_we_rise, r_dqoe_fall, WS_WR + 3, WS_WR + 4);
    else n_pass++;
    n_total++;
    if (r_done != 1 || r_done_at != WS_WR + 3 || r_busy1 !== 1'b1)
      $display("FAIL wr_done cnt=%0d at=%0d busy1=%b want 1/%0d/1", r_done, r_done_at, r_busy1, WS_WR + 3);
    else n_pass++;
    n_total++;
    if (sram_mem[8'h80][15:8] !== 8'h5A) $display("FAIL wr_mem got=%h want 5a", sram_mem[8'h80][15:8]);
    else n_pass++;
  endtask

  task automatic test_read();
    sram_mem[8'h80] = 16'h1234;
    run_req(1'b0, 1'b1, 22'h000100, 8'h00, 8'h34, 8, 12);
    n_total++;
    if (r_dato_at != WS_RD + 2 || dato !== 8'h34) $display("FAIL rd_lo at=%0d dato=%h want %0d/34", r_dato_at, dato, WS_RD + 2);
    else n_pass++;
    n_total++;
    if (r_oe_low != WS_RD + 1 || r_oe_pulses != 1 || r_lb_r !== 1'b0 || r_ub_r !== 1'b0)
      $display("FAIL rd_oe low=%0d pulses=%0d lb=%b ub=%b want %0d/1/0/0", r_oe_low, r_oe_pulses, r_lb_r, r_ub_r, WS_RD + 1);
    else n_pass++;
    run_req(1'b0, 1'b1, 22'h000101, 8'h00, 8'h12, 8, 12);
    n_total++;
    if (r_dato_at != WS_RD + 2 || dato !== 8'h12 || r_done_at != WS_RD + 3)
      $display("FAIL rd_hi at=%0d dato=%h done_at=%0d want %0d/12/%0d", r_dato_at, dato, r_done_at, WS_RD + 2, WS_RD + 3);
    else n_pass++;
    exp_dato = 8'h12;
  endtask

  task automatic test_long_strobe();
    run_req(1'b0, 1'b1, 22'h000100, 8'h00, 8'h34, 40, 44);
    n_total++;
    if (r_oe_pulses != 1 || r_done != 1) $display("FAIL long_once oe_pulses=%0d done=%0d want 1/1", r_oe_pulses, r_done);
    else n_pass++;
    n_total++;
    if (r_busy_drop != 41) $display("FAIL long_busy drop_at=%0d want 41", r_busy_drop);
    else n_pass++;
    exp_dato = 8'h34;
  endtask

  task automatic test_both_strobes();
    run_req(1'b1, 1'b1, 22'h000180, 8'hC3, exp_dato, 10, 14);
    n_total++;
    if (r_oe_pulses != 0 || r_we_pulses != 1 || r_done != 1)
      $display("FAIL both_dir oe=%0d we=%0d done=%0d want 0/1/1", r_oe_pulses, r_we_pulses, r_done);
    else n_pass++;
    n_total++;
    if (dato !== exp_dato || sram_mem[8'hC0][7:0] !== 8'hC3)
      $display("FAIL both_data dato=%h mem=%h want %h/c3", dato, sram_mem[8'hC0][7:0], exp_dato);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dn;
    dn = 0;
    @(negedge clk);
    req_ce = 1'b1; req_oe = 1'b1; req_we = 1'b0; req_addr = 22'h0000C2;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy} !== 7'b1111100 || dato !== 8'h00)
      $display("FAIL rst_mid pins=%b dato=%h want 1111100/00",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy}, dato);
    else n_pass++;
    rst = 1'b0; drop_req();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    n_total++;
    if (dn != 0 || busy !== 1'b0) $display("FAIL rst_nodone done=%0d busy=%b want 0/0", dn, busy);
    else n_pass++;
    run_req(1'b0, 1'b1, 22'h000100, 8'h00, 8'h34, 8, 12);
    n_total++;
    if (r_dato_at != WS_RD + 2 || r_done != 1) $display("FAIL rst_after at=%0d done=%0d want %0d/1", r_dato_at, r_done, WS_RD + 2);
    else n_pass++;
    exp_dato = 8'h34;
  endtask

  task automatic test_early_drop();
    run_req(1'b1, 1'b0, 22'h0000C4, 8'h77, exp_dato, 2, 12);
    n_total++;
    if (r_we_low != WS_WR || r_done != 1) $display("FAIL drop_wr we_low=%0d done=%0d want %0d/1", r_we_low, r_done, WS_WR);
    else n_pass++;
    n_total++;
    if (r_busy_drop != WS_WR + 4 || sram_mem[8'h62][7:0] !== 8'h77)
      $display("FAIL drop_idle busy_drop=%0d mem=%h want %0d/77", r_busy_drop, sram_mem[8'h62][7:0], WS_WR + 4);
    else n_pass++;
  endtask

  task automatic test_wrap();
    run_req(1'b1, 1'b0, 22'h3FFFFF, 8'hA5, exp_dato, 8, 12);
    n_total++;
    if (r_waddr !== 21'h1FFFFF || r_ub_w !== 1'b0 || r_lb_w !== 1'b1 || sram_mem[8'hFF][15:8] !== 8'hA5)
      $display("FAIL wrap addr=%h ub=%b lb=%b mem=%h want 1fffff/0/1/a5", r_waddr, r_ub_w, r_lb_w, sram_mem[8'hFF][15:8]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [7:0]    d, xd;
    logic          wr;
    int            hold, ws;
    for (int i = 0; i < 24; i++) begin
      a    = AW'($urandom_range(0, 127));
      d    = 8'($urandom);
      wr   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      ws   = wr ? WS_WR : WS_RD;
      xd   = wr ? exp_dato : ref_mem[a[6:0]];
      run_req(wr, ~wr, a, d, xd, hold, 18);
      if (wr) ref_mem[a[6:0]] = d;
      else    exp_dato = xd;
      n_total++;
      if (dato !== exp_dato) $display("FAIL rnd_dato i=%0d addr=%h got=%h want=%h", i, a, dato, exp_dato);
      else n_pass++;
      n_total++;
      if (r_done != 1 || r_done_at != ws + 3 || r_busy_drop != exp_busy_drop(ws, hold))
        $display("FAIL rnd_timing i=%0d done=%0d at=%0d busy_drop=%0d want 1/%0d/%0d",
                 i, r_done, r_done_at, r_busy_drop, ws + 3, exp_busy_drop(ws, hold));
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_long_strobe();
    test_both_strobes();
    test_reset_mid();
    test_early_drop();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
